// File: rtl/gf_poly_div_seq_pkg.sv
// Shared definitions for the GF(2^SIZE) polynomial divider: FSM encoding and
// the field reduction polynomial used by the multipliers.
package gf_poly_div_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INV  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Low-order terms of a primitive polynomial of degree w (x^w term implied).
  function automatic int unsigned prim_poly(input int unsigned w);
    case (w)
      2:       return 'h3;
      3:       return 'h3;
      4:       return 'h3;
      5:       return 'h5;
      6:       return 'h3;
      7:       return 'h3;
      default: return 'h1D;
    endcase
  endfunction

endpackage

// File: rtl/gf_poly_div_seq_if.sv
// Dividend/divisor request and quotient/remainder response channels of the
// polynomial divider.
interface gf_poly_div_seq_if #(
  parameter int unsigned SIZE = 8,
  parameter int unsigned n    = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [(2*n+1)*SIZE-1:0]   flat_z;
  logic [(n+1)*SIZE-1:0]     flat_q;
  logic                      out_valid;
  logic                      out_ready;
  logic [(n+1)*SIZE-1:0]     flat_quot;
  logic [n*SIZE-1:0]         flat_rem;
  logic                      div_err;

  modport master (
    output in_valid, flat_z, flat_q, out_ready,
    input  in_ready, out_valid, flat_quot, flat_rem, div_err
  );

  modport slave (
    input  in_valid, flat_z, flat_q, out_ready,
    output in_ready, out_valid, flat_quot, flat_rem, div_err
  );
endinterface

// File: rtl/gf_inv.sv
// Combinational GF(2^W) inverse as a^(2^W - 2) = product of a^(2^i), i=1..W-1.
// Zero maps to zero.
module gf_inv #(
  parameter  int unsigned m = 255,
  localparam int unsigned W = $clog2(m)
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  logic [W-1:0] sq  [0:W-1];
  logic [W-1:0] acc [1:W-1];

  assign sq[0] = a;

  for (genvar i = 1; i < W; i++) begin : g_sq
    gf_mul #(.m(m)) u_sq (.a(sq[i-1]), .b(sq[i-1]), .y(sq[i]));
  end

  assign acc[1] = sq[1];

  for (genvar i = 2; i < W; i++) begin : g_acc
    gf_mul #(.m(m)) u_acc (.a(acc[i-1]), .b(sq[i]), .y(acc[i]));
  end

  assign y = acc[W-1];

endmodule

// File: rtl/gf_mul.sv
// Combinational GF(2^W) multiplier: shift-and-add with modular reduction.
module gf_mul
  import gf_poly_div_seq_pkg::*;
#(
  parameter  int unsigned m = 255,
  localparam int unsigned W = $clog2(m)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] POLY = W'(prim_poly(W));

  logic [W-1:0] acc;
  logic [W-1:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[W-2:0], 1'b0} ^ (sh[W-1] ? POLY : '0);
    end
    y = acc;
  end

endmodule

// File: rtl/gf_poly_div_seq.sv
// Sequential long division of a degree-2n polynomial by a degree-n polynomial
// over GF(2^SIZE); one quotient coefficient per cycle.
module gf_poly_div_seq
  import gf_poly_div_seq_pkg::*;
#(
  parameter int unsigned m                = 255,
  parameter int unsigned SIZE             = $clog2(m),
  parameter int unsigned n                = 2,
  parameter int unsigned flat_size        = (n+1)*SIZE,
  parameter int unsigned large_array_size = (2*n+1)*SIZE
) (
  input  logic            clk,
  input  logic            rst,
  gf_poly_div_seq_if.slave bus
);

  localparam int unsigned KW = $clog2(n+1);

  typedef logic [SIZE-1:0] coef_t;

  state_e          state_q, state_d;
  coef_t [2*n:0]   r_q, r_d, r_step;
  coef_t [n:0]     dq_q, dq_d;
  coef_t [n:0]     quot_q, quot_d;
  coef_t [n:0]     quot_o_q, quot_o_d;
  coef_t [n-1:0]   rem_o_q, rem_o_d;
  coef_t [n:0]     prod;
  coef_t           inv_q, inv_d, inv_w, lead, c;
  logic [KW-1:0]   k_q, k_d;
  logic            err_q, err_d, err_o_q, err_o_d, ov_q, ov_d;

  gf_inv #(.m(m)) u_inv (.a(dq_q[n]), .y(inv_w));
  gf_mul #(.m(m)) u_c   (.a(lead), .b(inv_q), .y(c));

  for (genvar j = 0; j <= n; j++) begin : g_prod
    gf_mul #(.m(m)) u_p (.a(c), .b(dq_q[j]), .y(prod[j]));
  end

  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i <= n; i++) begin
      if (k_q == KW'(i)) lead = r_q[n+i];
    end
  end

  always_comb begin
    r_step = r_q;
    for (int unsigned i = 0; i <= n; i++) begin
      if (k_q == KW'(i)) begin
        for (int unsigned j = 0; j <= n; j++) r_step[i+j] = r_q[i+j] ^ prod[j];
      end
    end
  end

  // A zero leading coefficient is captured in INV and acted on in the first
  // DIV slot, so the error path still passes through one DIV cycle.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    dq_d     = dq_q;
    quot_d   = quot_q;
    inv_d    = inv_q;
    k_d      = k_q;
    err_d    = err_q;
    quot_o_d = quot_o_q;
    rem_o_d  = rem_o_q;
    err_o_d  = err_o_q;
    ov_d     = ov_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          r_d     = bus.flat_z[large_array_size-1:0];
          dq_d    = bus.flat_q[flat_size-1:0];
          quot_d  = '0;
          err_d   = 1'b0;
          state_d = S_INV;
        end
      end
      S_INV: begin
        inv_d   = inv_w;
        k_d     = KW'(n);
        state_d = S_DIV;
        if (dq_q[n] == '0) begin
          err_d  = 1'b1;
          quot_d = '0;
          r_d    = '0;
        end
      end
      S_DIV: begin
        if (err_q) begin
          state_d = S_DONE;
        end else begin
          r_d = r_step;
          for (int unsigned i = 0; i <= n; i++) begin
            if (k_q == KW'(i)) quot_d[i] = c;
          end
          if (k_q == '0) state_d = S_DONE;
          else           k_d = k_q - KW'(1);
        end
      end
      S_DONE: begin
        if (!ov_q) begin
          ov_d     = 1'b1;
          quot_o_d = quot_q;
          rem_o_d  = r_q[n-1:0];
          err_o_d  = err_q;
        end else if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      dq_q     <= '0;
      quot_q   <= '0;
      inv_q    <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
      quot_o_q <= '0;
      rem_o_q  <= '0;
      err_o_q  <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      dq_q     <= dq_d;
      quot_q   <= quot_d;
      inv_q    <= inv_d;
      k_q      <= k_d;
      err_q    <= err_d;
      quot_o_q <= quot_o_d;
      rem_o_q  <= rem_o_d;
      err_o_q  <= err_o_d;
      ov_q     <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = ov_q;
  assign bus.flat_quot = quot_o_q;
  assign bus.flat_rem  = rem_o_q;
  assign bus.div_err   = err_o_q;

endmodule

// File: tb/tb_gf_poly_div_seq.sv
// Self-checking bench for gf_poly_div_seq (m=255, SIZE=8, n=2).
module tb_gf_poly_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf_poly_div_seq_if #(.SIZE(8), .n(2)) bus ();

  gf_poly_div_seq #(.m(255), .SIZE(8), .n(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_t [0:509];
  int log_t [0:255];

  typedef struct {
    logic [39:0] z;
    logic [23:0] q;
    logic [23:0] quot;
    logic [15:0] rem;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Field arithmetic through log/antilog tables over x^8+x^4+x^3+x^2+1.
  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i]       = x;
      exp_t[i + 255] = x;
      log_t[x]       = i;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11D;
    end
    log_t[0] = 0;
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[log_t[a] + log_t[b]];
  endfunction

  function automatic int ginv(input int a);
    return exp_t[255 - log_t[a]];
  endfunction

  function automatic void model_div(input logic [39:0] z, input logic [23:0] q,
                                    output logic [23:0] quot, output logic [15:0] rem,
                                    output logic err);
    int r [5];
    int d [3];
    int c, li;
    for (int i = 0; i < 5; i++) r[i] = int'(z[i*8 +: 8]);
    for (int i = 0; i < 3; i++) d[i] = int'(q[i*8 +: 8]);
    quot = '0;
    rem  = '0;
    err  = (d[2] == 0);
    if (!err) begin
      li = ginv(d[2]);
      for (int k = 2; k >= 0; k--) begin
        c = gmul(r[k+2], li);
        quot[k*8 +: 8] = 8'(c);
        for (int j = 0; j < 3; j++) r[k+j] = r[k+j] ^ gmul(c, d[j]);
      end
      rem = {8'(r[1]), 8'(r[0])};
    end
  endfunction

  function automatic logic [39:0] poly_mul(input logic [23:0] p, input logic [23:0] q);
    int z [5];
    logic [39:0] res;
    for (int i = 0; i < 5; i++) z[i] = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        z[i+j] = z[i+j] ^ gmul(int'(p[i*8 +: 8]), int'(q[j*8 +: 8]));
    for (int i = 0; i < 5; i++) res[i*8 +: 8] = 8'(z[i]);
    return res;
  endfunction

  task automatic run_div(input logic [39:0] z, input logic [23:0] q,
                         output logic [23:0] quot, output logic [15:0] rem,
                         output logic err, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("in_ready before accept", 64'(bus.in_ready), 64'd1);
    bus.flat_z   = z;
    bus.flat_q   = q;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    quot = bus.flat_quot;
    rem  = bus.flat_rem;
    err  = bus.div_err;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  function automatic logic [23:0] rand_divisor(input logic allow_zero_lead);
    logic [23:0] q;
    q = 24'($urandom);
    if (!allow_zero_lead && q[23:16] == 8'h00) q[23:16] = 8'h01;
    return q;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] z;
    logic [23:0] q, p, quot, e_quot;
    logic [15:0] rem, e_rem;
    logic        err, e_err;
    int          lat;

    build_tables();
    vecs[0] = '{40'h0504030201, 24'h010000, 24'h050403, 16'h0201, 1'b0, 5};
    vecs[1] = '{40'h0100000000, 24'h010001, 24'h010001, 16'h0001, 1'b0, 5};
    vecs[2] = '{40'h0102030405, 24'h000703, 24'h000000, 16'h0000, 1'b1, 3};
    vecs[3] = '{40'h0000000000, 24'h010203, 24'h000000, 16'h0000, 1'b0, 5};
    vecs[4] = '{40'h00000000AB, 24'h010000, 24'h000000, 16'h00AB, 1'b0, 5};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flat_z    = '0;
    bus.flat_q    = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset flat_quot", 64'(bus.flat_quot), 64'd0);
    check("reset flat_rem",  64'(bus.flat_rem),  64'd0);
    check("reset div_err",   64'(bus.div_err),   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      run_div(vecs[i].z, vecs[i].q, quot, rem, err, lat);
      check($sformatf("vec%0d quot", i), 64'(quot), 64'(vecs[i].quot));
      check($sformatf("vec%0d rem", i),  64'(rem),  64'(vecs[i].rem));
      check($sformatf("vec%0d err", i),  64'(err),  64'(vecs[i].err));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      handshake();
      check($sformatf("vec%0d out_valid after handshake", i), 64'(bus.out_valid), 64'd0);
    end

    for (int i = 0; i < 200; i++) begin
      p = 24'($urandom);
      q = rand_divisor(1'b0);
      z = poly_mul(p, q);
      run_div(z, q, quot, rem, err, lat);
      check("roundtrip quot", 64'(quot), 64'(p));
      check("roundtrip rem",  64'(rem),  64'd0);
      check("roundtrip err",  64'(err),  64'd0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      handshake();
    end

    for (int i = 0; i < 100; i++) begin
      z = {8'($urandom), 32'($urandom)};
      q = rand_divisor($urandom_range(0, 7) == 0);
      model_div(z, q, e_quot, e_rem, e_err);
      run_div(z, q, quot, rem, err, lat);
      check("random quot", 64'(quot), 64'(e_quot));
      check("random rem",  64'(rem),  64'(e_rem));
      check("random err",  64'(err),  64'(e_err));
      check("random latency", 64'(lat), e_err ? 64'd3 : 64'd5);
      handshake();
    end

    // Backpressure: held outputs, ignored requests while busy.
    z = {8'($urandom), 32'($urandom)};
    q = rand_divisor(1'b0);
    model_div(z, q, e_quot, e_rem, e_err);
    run_div(z, q, quot, rem, err, lat);
    check("bp first quot", 64'(quot), 64'(e_quot));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.flat_z   = {8'($urandom), 32'($urandom)};
      bus.flat_q   = 24'h010000;
      @(posedge clk);
      #1;
      check("bp out_valid held", 64'(bus.out_valid), 64'd1);
      check("bp in_ready low",   64'(bus.in_ready),  64'd0);
      check("bp quot held",      64'(bus.flat_quot), 64'(e_quot));
      check("bp rem held",       64'(bus.flat_rem),  64'(e_rem));
    end
    bus.in_valid = 1'b0;
    handshake();
    check("bp out_valid after handshake", 64'(bus.out_valid), 64'd0);
    check("bp in_ready after handshake",  64'(bus.in_ready),  64'd1);
    z = {8'($urandom), 32'($urandom)};
    q = rand_divisor(1'b0);
    model_div(z, q, e_quot, e_rem, e_err);
    run_div(z, q, quot, rem, err, lat);
    check("bp next quot",    64'(quot), 64'(e_quot));
    check("bp next rem",     64'(rem),  64'(e_rem));
    check("bp next latency", 64'(lat),  64'd5);
    handshake();

    // Reset while the k=1 division step is in progress.
    @(negedge clk);
    bus.flat_z   = 40'h0504030201;
    bus.flat_q   = 24'h010000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort out_valid",   64'(bus.out_valid), 64'd0);
    check("abort flat_quot",   64'(bus.flat_quot), 64'd0);
    check("abort flat_rem",    64'(bus.flat_rem),  64'd0);
    check("abort div_err",     64'(bus.div_err),   64'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("abort no late result", 64'(bus.out_valid), 64'd0);
    z = {8'($urandom), 32'($urandom)};
    q = rand_divisor(1'b0);
    model_div(z, q, e_quot, e_rem, e_err);
    run_div(z, q, quot, rem, err, lat);
    check("post-abort quot",    64'(quot), 64'(e_quot));
    check("post-abort rem",     64'(rem),  64'(e_rem));
    check("post-abort latency", 64'(lat),  64'd5);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
